// File: rtl/prog_launcher.sv
// Purpose: sequences the fetch PC through a program run (load base, release fetch, catch halt),
//          reports the run's cycle count, and flags an invalid program select (plus a watchdog
//          expiry when PROG_WATCHDOG_EN is defined).
// Latency: PcLoad one cycle after an accepted Req. FetchHold follows HaltSeen in the same cycle.
//          Done rises one cycle after halt.
// Backpressure: Req is a level held by the bench until Done. Done holds until Req drops.
//          Req/ProgSel are ignored outside IDLE.
module prog_launcher #(
    parameter int              PC_W        = 10,
    parameter int              CNT_W       = 16,
    parameter logic [PC_W-1:0] BASE_0      = 10'd0,
    parameter logic [PC_W-1:0] BASE_1      = 10'd256,
    parameter logic [PC_W-1:0] BASE_2      = 10'd512,
    parameter int              WDOG_CYCLES = 4096
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic [1:0]       ProgSel,
    input  logic             HaltSeen,
    output logic             FetchHold,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcTarget,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [1:0]       CurProg,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   wdog_hit;

    // Base address of each program; index 3 never reaches here because it is rejected in IDLE.
    function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd1:    base_of = BASE_1;
            2'd2:    base_of = BASE_2;
            default: base_of = BASE_0;
        endcase
    endfunction

`ifdef PROG_WATCHDOG_EN
    // Expiry is the RUN cycle whose increment brings CycleCnt up to WDOG_CYCLES.
    assign wdog_hit = (state == S_RUN) && (CycleCnt >= CNT_W'(WDOG_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and fetch-control outputs. A halt or an expiry freezes the PC in the same cycle.
    always_comb begin
        state_nxt = state;
        FetchHold = 1'b1;
        PcLoad    = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Req && (ProgSel != 2'd3)) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                FetchHold = 1'b0;
                PcLoad    = 1'b1;
                Busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                Busy      = 1'b1;
                FetchHold = HaltSeen | wdog_hit;
                if (HaltSeen || wdog_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                Done = 1'b1;
                if (!Req) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // While Reset is held, keep fetch frozen so nothing moves before state settles.
        if (Reset) begin
            FetchHold = 1'b1;
            PcLoad    = 1'b0;
        end
    end

    // Program select, target, error flag and run-cycle counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PcTarget <= '0;
            Error    <= 1'b0;
            CurProg  <= 2'd0;
            CycleCnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        if (ProgSel == 2'd3) begin
                            Error <= 1'b1;
                        end else begin
                            // Target is set on accept so that it is already valid during LOAD.
                            CurProg  <= ProgSel;
                            Error    <= 1'b0;
                            PcTarget <= base_of(ProgSel);
                        end
                    end
                end
                S_LOAD: CycleCnt <= '0;
                S_RUN: begin
                    if (CycleCnt != {CNT_W{1'b1}}) CycleCnt <= CycleCnt + 1'b1;
                    if (wdog_hit && !HaltSeen) Error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
